// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default link settings and
// the oversample divider calculation used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    localparam int unsigned FCLK_DEFAULT  = 100_000_000;
    localparam int unsigned FUART_DEFAULT = 115_200;
    localparam int unsigned OVS_DEFAULT   = 16;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int unsigned calc_div(input int unsigned fclk,
                                             input int unsigned fuart,
                                             input int unsigned ovs);
        return fclk / (fuart * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via
// clr so the tick phase can be aligned to a detected start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 54
) (
    input  logic clk_Rx,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt_q;
    logic [W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (clr || (div_cnt_q == LAST)) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_Rx or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: mid-bit start validation, mid-bit
// data sampling, stop-bit check with framing-error pulse and break lockout.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned Fclk  = FCLK_DEFAULT,
    parameter int unsigned Fuart = FUART_DEFAULT,
    parameter int unsigned OVS   = OVS_DEFAULT,
    parameter int unsigned DIV   = calc_div(Fclk, Fuart, OVS)
) (
    input  logic       clk_Rx,
    input  logic       rst,
    input  logic       Rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned SMP_W = $clog2(OVS);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVS / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);

    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    uart_state_e state_q, state_d;
    logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             div_clr;
    logic             tick;

    // Flops reset high so reset does not look like a start edge.
    always_ff @(posedge clk_Rx or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_Rx (clk_Rx),
        .rst    (rst),
        .clr    (div_clr),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        div_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    smp_cnt_d = '0;
                    div_clr   = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    if (smp_cnt_q == SMP_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rx_s) begin
                            state_d   = DATA;
                            smp_cnt_d = '0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (smp_cnt_q == SMP_LAST) begin
                        shreg_d   = {rx_s, shreg_q[7:1]};
                        smp_cnt_d = '0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (smp_cnt_q == SMP_LAST) begin
                        smp_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) must not start a new frame.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_Rx or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            smp_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced clock (96 clocks per bit) with a
// frame-level expectation queue checked against the DUT on every cycle.
module tb_uart_rx;

    localparam int unsigned FCLK    = 11_059_200;
    localparam int unsigned FUART   = 115_200;
    localparam int unsigned OVS     = 16;
    localparam int          BIT     = 96;
    localparam int          LAT_MIN = (BIT * 19) / 2;
    localparam int          LAT_MAX = LAT_MIN + 6;

    logic       clk;
    logic       rst;
    logic       Rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         start_cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         n_valid = 0;
    int         n_ferr = 0;

    uart_rx #(
        .Fclk  (FCLK),
        .Fuart (FUART),
        .OVS   (OVS)
    ) dut (
        .clk_Rx    (clk),
        .rst       (rst),
        .Rx_in     (Rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Leaves the caller 1 time unit after a rising edge, n edges later.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
        ev_t        ev;
        logic [9:0] fr;
        fr           = {stop, b, 1'b0};
        ev.is_err    = !stop;
        ev.data      = b;
        ev.start_cyc = cyc;
        exp_q.push_back(ev);
        for (int i = 0; i < 10; i++) begin
            Rx_in = fr[i];
            hold(per);
        end
    endtask

    task automatic monitor();
        ev_t ev;
        int  lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_data = 8'h00;
            end else begin
                if (rx_valid || frame_err) begin
                    if (rx_valid) n_valid++;
                    if (frame_err) n_ferr++;
                    check("valid_ferr_exclusive", 32'(rx_valid && frame_err), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b expected no pulse (cycle %0d)",
                                 rx_valid, frame_err, cyc);
                    end else begin
                        ev  = exp_q.pop_front();
                        lat = cyc - ev.start_cyc;
                        check("pulse_kind", {30'd0, rx_valid, frame_err},
                              ev.is_err ? 32'd1 : 32'd2);
                        check("pulse_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
                        if (!ev.is_err) model_data = ev.data;
                    end
                end
                check("rx_data_model", 32'(rx_data), 32'(model_data));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        Rx_in = 1'b1;
        fork
            monitor();
        join_none

        hold(3);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_outputs", {29'd0, rx_valid, frame_err, rx_busy}, 32'd0);
        rst = 1'b0;
        hold(BIT);
        check("idle_after_reset_busy", 32'(rx_busy), 32'd0);

        // Single good frame
        send_frame(8'hA5, BIT, 1'b1);
        hold(BIT);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_busy_low", 32'(rx_busy), 32'd0);
        check("a5_valid_count", 32'(n_valid), 32'd1);
        check("a5_pending", 32'(exp_q.size()), 32'd0);

        // Sub-half-bit glitch
        Rx_in = 1'b0;
        hold(10);
        check("glitch_busy_seen", 32'(rx_busy), 32'd1);
        hold(22);
        Rx_in = 1'b1;
        for (int i = 0; i < BIT / 2 && rx_busy; i++) hold(1);
        check("glitch_busy_clears", 32'(rx_busy), 32'd0);
        hold(BIT);
        check("glitch_no_pulses", 32'(n_valid + n_ferr), 32'd1);

        // Framing error followed by a long break, then a good frame
        send_frame(8'h3C, BIT, 1'b0);
        hold(2000);
        check("break_busy_held", 32'(rx_busy), 32'd1);
        Rx_in = 1'b1;
        hold(2 * BIT);
        check("ferr_rx_data_kept", 32'(rx_data), 32'hA5);
        check("ferr_count", 32'(n_ferr), 32'd1);
        check("ferr_busy_low", 32'(rx_busy), 32'd0);
        send_frame(8'h11, BIT, 1'b1);
        hold(BIT);
        check("after_ferr_rx_data", 32'(rx_data), 32'h11);
        check("after_ferr_valid_count", 32'(n_valid), 32'd2);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'hFF, BIT, 1'b1);
        send_frame(8'h55, BIT, 1'b1);
        hold(BIT);
        check("b2b_last_data", 32'(rx_data), 32'h55);
        check("b2b_valid_count", 32'(n_valid), 32'd5);
        check("b2b_pending", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of data bit 4 of 0xC3 (start + bits 0..3 = 1,1,0,0)
        Rx_in = 1'b0; hold(BIT);
        Rx_in = 1'b1; hold(2 * BIT);
        Rx_in = 1'b0; hold(2 * BIT);
        hold(BIT / 2);
        rst = 1'b1;
        #1;
        check("midframe_rst_rx_data", 32'(rx_data), 32'h0);
        check("midframe_rst_outputs", {29'd0, rx_valid, frame_err, rx_busy}, 32'd0);
        Rx_in = 1'b1;
        hold(5);
        rst = 1'b0;
        hold(BIT);
        check("post_rst_no_pulse", 32'(n_valid + n_ferr), 32'd6);
        send_frame(8'h5A, BIT, 1'b1);
        hold(BIT);
        check("post_rst_rx_data", 32'(rx_data), 32'h5A);

        // Sender baud error of roughly -3% and +3%
        send_frame(8'h96, 93, 1'b1);
        hold(BIT);
        check("fast_sender_rx_data", 32'(rx_data), 32'h96);
        check("fast_sender_ferr", 32'(n_ferr), 32'd1);
        Rx_in = 1'b1;
        check("clear_marker", 32'(n_valid), 32'd7);
        send_frame(8'h96, 99, 1'b1);
        hold(BIT);
        check("slow_sender_rx_data", 32'(rx_data), 32'h96);
        check("slow_sender_ferr", 32'(n_ferr), 32'd1);
        check("slow_sender_valid_count", 32'(n_valid), 32'd8);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
